// File: rtl/sort7_stream_ctrl.sv
// sort7_stream_ctrl: gathers up to 7 serial words, presents them to an external
// 7-input ascending sorter, captures the sorted result and streams the first
// frame_len words back out. Optional sorter self-check under SORT7_CHECK_EN.
module sort7_stream_ctrl #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       SORT_LAT = 0,
  parameter logic [DATA_W-1:0] PAD_VAL  = '1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic [7*DATA_W-1:0] srt_in,
  input  logic [7*DATA_W-1:0] srt_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                sort_err
);

  localparam int unsigned NSLOT  = 7;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WCNT_W = (SORT_LAT > 0) ? $clog2(SORT_LAT + 1) : 1;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        r_state,     w_state_nxt;
  logic [CNT_W-1:0]  r_count,     w_count_nxt;
  logic [CNT_W-1:0]  r_frame_len, w_len_nxt;
  logic [CNT_W-1:0]  r_rd_idx,    w_rd_nxt;
  logic [WCNT_W-1:0] r_wait_cnt,  w_wcnt_nxt;
  logic [DATA_W-1:0] r_slots [NSLOT];
  logic [DATA_W-1:0] w_slots_nxt [NSLOT];
  logic [DATA_W-1:0] r_obuf [NSLOT];
  logic [DATA_W-1:0] w_obuf_nxt [NSLOT];
  logic              r_in_ready,  w_ir_nxt;
  logic              r_out_valid, w_ov_nxt;
  logic [DATA_W-1:0] r_out_data,  w_od_nxt;
  logic              r_out_last,  w_ol_nxt;
  logic              r_busy,      w_busy_nxt;
  logic              w_capture;
  logic [CNT_W-1:0]  w_rd_inc;

  // Next-state and next-output logic for the load / wait / drain sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_len_nxt   = r_frame_len;
    w_rd_nxt    = r_rd_idx;
    w_wcnt_nxt  = r_wait_cnt;
    w_slots_nxt = r_slots;
    w_obuf_nxt  = r_obuf;
    w_ir_nxt    = r_in_ready;
    w_ov_nxt    = r_out_valid;
    w_od_nxt    = r_out_data;
    w_ol_nxt    = r_out_last;
    w_capture   = 1'b0;
    w_rd_inc    = r_rd_idx + CNT_W'(1);

    case (r_state)
      ST_LOAD: begin
        if (in_valid && r_in_ready) begin
          for (int unsigned k = 0; k < NSLOT; k++) begin
            if (CNT_W'(k) == r_count) w_slots_nxt[k] = in_data;
          end
          w_count_nxt = r_count + CNT_W'(1);
          // in_last or the 7th word closes the frame
          if (in_last || (r_count == CNT_W'(NSLOT - 1))) begin
            w_state_nxt = ST_WAIT;
            w_len_nxt   = r_count + CNT_W'(1);
            w_wcnt_nxt  = '0;
            w_ir_nxt    = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == WCNT_W'(SORT_LAT)) begin
          w_capture = 1'b1;
          for (int unsigned k = 0; k < NSLOT; k++) begin
            w_obuf_nxt[k] = srt_out[k*DATA_W +: DATA_W];
          end
          w_rd_nxt    = '0;
          w_state_nxt = ST_DRAIN;
        end else begin
          w_wcnt_nxt = r_wait_cnt + WCNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!r_out_valid) begin
          // first drain cycle presents obuf[0]
          w_ov_nxt = 1'b1;
          w_od_nxt = r_obuf[0];
          w_ol_nxt = (r_frame_len == CNT_W'(1));
        end else if (out_ready) begin
          if (r_out_last) begin
            w_state_nxt = ST_LOAD;
            w_ov_nxt    = 1'b0;
            w_ol_nxt    = 1'b0;
            w_count_nxt = '0;
            w_ir_nxt    = 1'b1;
            for (int unsigned k = 0; k < NSLOT; k++) w_slots_nxt[k] = PAD_VAL;
          end else begin
            w_rd_nxt = w_rd_inc;
            w_od_nxt = r_obuf[w_rd_inc];
            w_ol_nxt = (w_rd_inc == (r_frame_len - CNT_W'(1)));
          end
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
        w_count_nxt = '0;
        w_ir_nxt    = 1'b1;
        w_ov_nxt    = 1'b0;
        w_ol_nxt    = 1'b0;
      end
    endcase

    w_busy_nxt = !((w_state_nxt == ST_LOAD) && (w_count_nxt == '0));
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_count     <= '0;
      r_frame_len <= '0;
      r_rd_idx    <= '0;
      r_wait_cnt  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      for (int unsigned k = 0; k < NSLOT; k++) begin
        r_slots[k] <= PAD_VAL;
        r_obuf[k]  <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_frame_len <= w_len_nxt;
      r_rd_idx    <= w_rd_nxt;
      r_wait_cnt  <= w_wcnt_nxt;
      r_in_ready  <= w_ir_nxt;
      r_out_valid <= w_ov_nxt;
      r_out_data  <= w_od_nxt;
      r_out_last  <= w_ol_nxt;
      r_busy      <= w_busy_nxt;
      r_slots     <= w_slots_nxt;
      r_obuf      <= w_obuf_nxt;
    end
  end

  // Sorter inputs mirror the load slots
  always_comb begin
    srt_in = '0;
    for (int unsigned k = 0; k < NSLOT; k++) srt_in[k*DATA_W +: DATA_W] = r_slots[k];
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

`ifdef SORT7_CHECK_EN
  logic       r_sort_err;
  logic       w_chk_bad;
  logic [3:0] w_pad_cnt;

  // Sorter sanity: ascending order and enough pads survive for a short frame
  always_comb begin
    w_chk_bad = 1'b0;
    w_pad_cnt = '0;
    for (int unsigned k = 0; k < NSLOT - 1; k++) begin
      if (srt_out[k*DATA_W +: DATA_W] > srt_out[(k+1)*DATA_W +: DATA_W]) w_chk_bad = 1'b1;
    end
    for (int unsigned k = 0; k < NSLOT; k++) begin
      if (srt_out[k*DATA_W +: DATA_W] == PAD_VAL) w_pad_cnt = w_pad_cnt + 4'd1;
    end
    if (w_pad_cnt < (4'(NSLOT) - {1'b0, r_frame_len})) w_chk_bad = 1'b1;
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) r_sort_err <= 1'b0;
    else if (w_capture && w_chk_bad) r_sort_err <= 1'b1;
  end

  assign sort_err = r_sort_err;
`else
  assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort7_stream_ctrl.sv
// Bench for sort7_stream_ctrl: directed and random frames, an external sorter
// model, and a queue scoreboard checked by an independent output monitor.
module tb_sort7_stream_ctrl;

  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] PAD = '1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic          first;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            in_last = 1'b0;
  logic [7*DW-1:0] srt_in;
  logic [7*DW-1:0] srt_out;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            busy;
  logic            sort_err;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   hs_first = 0;
  int   hs_last = 0;
  int   hs_count = 0;
  int   rdy_mode = 0;
  int   pidx = 0;
  logic pat [4];
  logic bad_sorter = 1'b0;
  exp_t exp_q[$];

  sort7_stream_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .srt_in(srt_in), .srt_out(srt_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .sort_err(sort_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7*DW-1:0] sort_net(input logic [7*DW-1:0] x);
    logic [DW-1:0] a[$];
    logic [7*DW-1:0] r;
    for (int k = 0; k < 7; k++) a.push_back(x[k*DW +: DW]);
    a.sort();
    r = '0;
    for (int k = 0; k < 7; k++) r[k*DW +: DW] = a[k];
    return r;
  endfunction

  function automatic logic [7*DW-1:0] broken_net();
    logic [7*DW-1:0] r;
    for (int k = 0; k < 7; k++) r[k*DW +: DW] = PAD;
    r[0 +: DW]    = 32'd1;
    r[DW +: DW]   = 32'd5;
    r[2*DW +: DW] = 32'd3;
    return r;
  endfunction

  // External sorter: correct ascending sort, or a deliberately broken one
  always_comb srt_out = bad_sorter ? broken_net() : sort_net(srt_in);

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Consumer ready pattern, changed just after each posedge
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: pops the scoreboard on every output handshake
  logic          prev_ov = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (out_valid && !prev_ov) chk("first_out_latency", DW'(cyc - last_acc_cyc), 32'd2);
      if (prev_stall) begin
        chk("stall_hold_data", out_data, prev_d);
        chk("stall_hold_last", 32'(out_last), 32'(prev_l));
      end
      if (out_valid) chk("no_overlap_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", out_data, PAD ^ out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", 32'(out_last), 32'(e.last));
          if (e.first) hs_first = cyc;
          hs_last = cyc;
        end
        hs_count++;
      end
      prev_ov    = out_valid;
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
    end
  end

  task automatic push_sorted(input logic [DW-1:0] w[$]);
    logic [DW-1:0] s[$];
    exp_t e;
    s = w;
    s.sort();
    for (int i = 0; i < s.size(); i++) begin
      e.d = s[i];
      e.last = (i == s.size() - 1);
      e.first = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] w[$], input bit use_last,
                            input bit gaps, input bit push_exp);
    int n;
    for (int i = 0; i < w.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w[i];
      in_last  = use_last && (i == w.size() - 1);
      n = 0;
      while (!in_ready && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) chk("in_ready_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      last_acc_cyc = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    if (push_exp) push_sorted(w);
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 2000), 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_word();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return PAD;
    if (sel < 3) return DW'($urandom_range(0, 7));
    return DW'($urandom);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q[$];
    int h0, len;
    bit ul;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sort_err", 32'(sort_err), 32'd0);
    for (int k = 0; k < 7; k++) chk("rst_slot_pad", srt_in[k*DW +: DW], PAD);
    rst = 1'b0;

    // Full frame closed by the 7th word
    rdy_mode = 0;
    q = {32'd9, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd5};
    send_frame(q, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("in_ready_drop_after_7", 32'(in_ready), 32'd0);
    chk("busy_in_wait", 32'(busy), 32'd1);
    wait_drained();
    chk("full_frame_back_to_back", DW'(hs_last - hs_first), 32'd6);

    // Short frame: padded slots and three outputs
    q = {32'd40, 32'd10, 32'd30};
    send_frame(q, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("short_slot0", srt_in[0 +: DW], 32'd40);
    chk("short_slot2", srt_in[2*DW +: DW], 32'd30);
    for (int k = 3; k < 7; k++) chk("short_slot_pad", srt_in[k*DW +: DW], PAD);
    wait_drained();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Real data equal to the pad value
    h0 = hs_count;
    q = {PAD, 32'd5};
    send_frame(q, 1'b1, 1'b0, 1'b1);
    wait_drained();
    chk("pad_data_handshakes", DW'(hs_count - h0), 32'd2);

    // Output backpressure
    pidx = 0;
    rdy_mode = 1;
    q = {32'd4, 32'd4, 32'd1};
    send_frame(q, 1'b1, 1'b0, 1'b1);
    wait_drained();
    rdy_mode = 0;

    // Reset mid-frame discards the partial frame
    q = {32'd11, 32'd12, 32'd13};
    send_frame(q, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) chk("midrst_slot_pad", srt_in[k*DW +: DW], PAD);
    h0 = hs_count;
    q = {32'd6, 32'd2};
    send_frame(q, 1'b1, 1'b0, 1'b1);
    wait_drained();
    chk("midrst_handshakes", DW'(hs_count - h0), 32'd2);

    // Random frames with random gaps and backpressure
    rdy_mode = 2;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 7);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(rand_word());
      ul = (len < 7) ? 1'b1 : 1'($urandom_range(0, 1));
      send_frame(q, ul, 1'b1, 1'b1);
    end
    wait_drained();
    rdy_mode = 0;

`ifdef SORT7_CHECK_EN
    // Broken sorter raises a sticky error; data still drains
    bad_sorter = 1'b1;
    q = {32'd7, 32'd8, 32'd9};
    send_frame(q, 1'b1, 1'b0, 1'b0);
    q = {32'd1, 32'd5, 32'd3};
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.d = q[i];
      e.last = (i == 2);
      e.first = (i == 0);
      exp_q.push_back(e);
    end
    wait_drained();
    chk("sort_err_set", 32'(sort_err), 32'd1);
    bad_sorter = 1'b0;
    q = {32'd2, 32'd1};
    send_frame(q, 1'b1, 1'b0, 1'b1);
    wait_drained();
    chk("sort_err_sticky", 32'(sort_err), 32'd1);
    pulse_reset();
    chk("sort_err_cleared", 32'(sort_err), 32'd0);
`else
    chk("sort_err_tied_low", 32'(sort_err), 32'd0);
`endif

    chk("scoreboard_empty", DW'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
